bypass_scoreboard: RTL and testbench

- Parametrised successor to the core's fixed two-port EX/ME bypass muxes.
- Tracks every in-flight register write in a DEPTH-stage shift pipeline behind EX.
- Forwards the youngest matching value to NUM_READ decode read ports and raises a load-use stall when the youngest producer's data is not yet available.
- Sits between decoder/register file and the EX/ME/WB stages; its last stage drives register-file writeback.

---
 rtl/bypass_scoreboard.sv | 114 +++++++++++
 tb/tb_bypass_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: in-flight write tracker with youngest-first operand forwarding, load-use stall and writeback.
module bypass_scoreboard #(
    parameter int DW       = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_READ = 2,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 0,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   hold_i,
    input  logic                   flush_i,
    input  logic                   ex_valid_i,
    input  logic [RW-1:0]          ex_dest_i,
    input  logic                   ex_is_load_i,
    input  logic [DW-1:0]          ex_result_i,
    input  logic [DW-1:0]          mem_data_i,
    input  logic [NUM_READ*RW-1:0] rd_idx_i,
    input  logic [NUM_READ*DW-1:0] rf_data_i,
    output logic [NUM_READ*DW-1:0] fwd_data_o,
    output logic                   stall_o,
    output logic                   wb_valid_o,
    output logic [RW-1:0]          wb_dest_o,
    output logic [DW-1:0]          wb_data_o,
    output logic [15:0]            stall_count_o
);
    logic [DEPTH:1] vld_q, vld_d, ld_q, ld_d, rdy_q, rdy_d;
    logic [RW-1:0]  dst_q [1:DEPTH];
    logic [RW-1:0]  dst_d [1:DEPTH];
    logic [DW-1:0]  dat_q [1:DEPTH];
    logic [DW-1:0]  dat_d [1:DEPTH];
    logic [15:0]    cnt_q, cnt_d;
    logic [DEPTH:0] e_vld, e_ld, e_rdy;
    logic [RW-1:0]  e_dst [0:DEPTH];
    logic [DW-1:0]  e_dat [0:DEPTH];
    logic [NUM_READ-1:0] port_stall;
    logic           rdy;
    logic [DW-1:0]  val;
    logic [RW-1:0]  idx;

    // Effective stage view: the stage at LOAD_LAT sees its load data live on mem_data_i.
    always_comb begin
        e_vld[0] = ex_valid_i && !(ZERO_REG != 0 && ex_dest_i == '0);
        e_ld[0]  = ex_is_load_i;
        e_rdy[0] = !ex_is_load_i;
        e_dst[0] = ex_dest_i;
        e_dat[0] = ex_result_i;
        for (int k = 1; k <= DEPTH; k++) begin
            e_vld[k] = vld_q[k];
            e_ld[k]  = ld_q[k];
            e_rdy[k] = rdy_q[k] || (e_ld[k] && k == LOAD_LAT);
            e_dst[k] = dst_q[k];
            e_dat[k] = (e_ld[k] && k == LOAD_LAT) ? mem_data_i : dat_q[k];
        end
    end

    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            vld_d[k] = hold_i ? vld_q[k] : e_vld[k-1] && !(k == 1 && flush_i);
            ld_d[k]  = hold_i ? ld_q[k]  : e_ld[k-1];
            rdy_d[k] = hold_i ? rdy_q[k] : e_rdy[k-1];
            dst_d[k] = hold_i ? dst_q[k] : e_dst[k-1];
            dat_d[k] = hold_i ? dat_q[k] : e_dat[k-1];
        end
        cnt_d = (!hold_i && stall_o && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    // Scan oldest to youngest so the youngest match overwrites; a non-ready youngest stalls.
    always_comb begin
        port_stall = '0;
        fwd_data_o = rf_data_i;
        rdy = 1'b1;
        val = '0;
        idx = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            idx = rd_idx_i[p*RW +: RW];
            rdy = 1'b1;
            val = rf_data_i[p*DW +: DW];
            for (int k = DEPTH; k >= 0; k--)
                if (rst_ni && !(ZERO_REG != 0 && idx == '0) && e_vld[k] && e_dst[k] == idx) begin
                    rdy = e_rdy[k];
                    val = e_dat[k];
                end
            port_stall[p] = !rdy;
            fwd_data_o[p*DW +: DW] = val;
        end
    end

    assign stall_o       = |port_stall;
    assign wb_valid_o    = vld_q[DEPTH];
    assign wb_dest_o     = dst_q[DEPTH];
    assign wb_data_o     = e_dat[DEPTH];
    assign stall_count_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            ld_q  <= '0;
            rdy_q <= '0;
            dst_q <= '{default: '0};
            dat_q <= '{default: '0};
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            ld_q  <= ld_d;
            rdy_q <= rdy_d;
            dst_q <= dst_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb_bypass_scoreboard: two configurations driven in lockstep against a queue-based reference model.
module tb_bypass_scoreboard;
    logic clk = 1'b0, rst_n = 1'b0, hold = 1'b0, flush = 1'b0, ex_valid = 1'b0, ex_is_load = 1'b0;
    logic [3:0]  ex_dest = '0;
    logic [15:0] ex_result = '0, mem_data = '0;
    logic [7:0]  rd_idx = '0;
    logic [31:0] rf_data = '0;
    logic [31:0] fwd_a, fwd_b;
    logic        stall_a, stall_b, wbv_a, wbv_b;
    logic [3:0]  wbd_a, wbd_b;
    logic [15:0] wbdat_a, wbdat_b, cnt_a, cnt_b;
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    bypass_scoreboard #(.DW(16), .NUM_REGS(16), .NUM_READ(2), .DEPTH(2), .LOAD_LAT(1), .ZERO_REG(0)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .hold_i(hold), .flush_i(flush), .ex_valid_i(ex_valid),
        .ex_dest_i(ex_dest), .ex_is_load_i(ex_is_load), .ex_result_i(ex_result), .mem_data_i(mem_data),
        .rd_idx_i(rd_idx), .rf_data_i(rf_data), .fwd_data_o(fwd_a), .stall_o(stall_a),
        .wb_valid_o(wbv_a), .wb_dest_o(wbd_a), .wb_data_o(wbdat_a), .stall_count_o(cnt_a));

    bypass_scoreboard #(.DW(16), .NUM_REGS(16), .NUM_READ(2), .DEPTH(3), .LOAD_LAT(3), .ZERO_REG(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .hold_i(hold), .flush_i(flush), .ex_valid_i(ex_valid),
        .ex_dest_i(ex_dest), .ex_is_load_i(ex_is_load), .ex_result_i(ex_result), .mem_data_i(mem_data),
        .rd_idx_i(rd_idx), .rf_data_i(rf_data), .fwd_data_o(fwd_b), .stall_o(stall_b),
        .wb_valid_o(wbv_b), .wb_dest_o(wbd_b), .wb_data_o(wbdat_b), .stall_count_o(cnt_b));

    // One record per advancing edge, youngest first; md[a] is mem_data seen when leaving age a.
    typedef struct packed {
        logic             v;
        logic [3:0]       d;
        logic             ld;
        logic [15:0]      r;
        logic [3:0][15:0] md;
    } rec_t;
    rec_t q[$];
    int mcnt_a = 0, mcnt_b = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Returns {stall, value} for read port p of a configuration.
    function automatic logic [16:0] lookup(input bit zr, input int dep, input int ll, input int p);
        logic [3:0]  idx;
        logic [15:0] rf;
        idx = rd_idx[p*4 +: 4];
        rf  = rf_data[p*16 +: 16];
        if (!rst_n || (zr && idx == 4'd0)) return {1'b0, rf};
        if (ex_valid && ex_dest == idx) return {ex_is_load, ex_result};
        for (int i = 0; i < dep && i < q.size(); i++)
            if (q[i].v && q[i].d == idx) begin
                if (!q[i].ld) return {1'b0, q[i].r};
                if (i + 1 < ll) return {1'b1, 16'h0};
                if (i + 1 == ll) return {1'b0, mem_data};
                return {1'b0, q[i].md[ll]};
            end
        return {1'b0, rf};
    endfunction

    function automatic bit mstall(input bit zr, input int dep, input int ll);
        logic [16:0] a, b;
        a = lookup(zr, dep, ll, 0);
        b = lookup(zr, dep, ll, 1);
        return a[16] | b[16];
    endfunction

    // Returns {valid, dest, data} of the writeback stage.
    function automatic logic [20:0] mwb(input bit zr, input int dep, input int ll);
        rec_t r;
        logic [15:0] data;
        if (!rst_n || q.size() < dep) return '0;
        r = q[dep-1];
        data = !r.ld ? r.r : (dep == ll ? mem_data : r.md[ll]);
        return {r.v && !(zr && r.d == 4'd0), r.d, data};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        rec_t t;
        if (!rst_n) begin
            q.delete();
            mcnt_a = 0;
            mcnt_b = 0;
        end else if (!hold) begin
            if (mstall(1'b0, 2, 1) && mcnt_a != 65535) mcnt_a++;
            if (mstall(1'b1, 3, 3) && mcnt_b != 65535) mcnt_b++;
            for (int i = 0; i < q.size(); i++) begin
                t = q[i];
                t.md[i+1] = mem_data;
                q[i] = t;
            end
            t = '0;
            t.v = ex_valid && !flush;
            t.d = ex_dest;
            t.ld = ex_is_load;
            t.r = ex_result;
            q.push_front(t);
            if (q.size() > 3) void'(q.pop_back());
        end
    end

    task automatic check_inst(input string nm, input bit zr, input int dep, input int ll,
                              input logic [31:0] fwd, input logic st, input logic wv,
                              input logic [3:0] wd, input logic [15:0] wdat, input logic [15:0] cnt,
                              input int mc);
        logic [16:0] l0, l1;
        logic [20:0] w;
        l0 = lookup(zr, dep, ll, 0);
        l1 = lookup(zr, dep, ll, 1);
        w  = mwb(zr, dep, ll);
        chk({nm, ".stall"}, st, l0[16] | l1[16]);
        if (!l0[16]) chk({nm, ".fwd0"}, fwd[15:0], l0[15:0]);
        if (!l1[16]) chk({nm, ".fwd1"}, fwd[31:16], l1[15:0]);
        chk({nm, ".wb_valid"}, wv, w[20]);
        if (w[20]) begin
            chk({nm, ".wb_dest"}, wd, w[19:16]);
            chk({nm, ".wb_data"}, wdat, w[15:0]);
        end
        chk({nm, ".stall_count"}, cnt, mc[15:0]);
    endtask

    always @(negedge clk) begin
        check_inst("A", 1'b0, 2, 1, fwd_a, stall_a, wbv_a, wbd_a, wbdat_a, cnt_a, mcnt_a);
        check_inst("B", 1'b1, 3, 3, fwd_b, stall_b, wbv_b, wbd_b, wbdat_b, cnt_b, mcnt_b);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ex_valid = 1'b1; ex_dest = 4'd3; ex_result = 16'h1234; rd_idx = 8'h03; rf_data = 32'h5555_AAAA;
        #12;
        chk("rst_fwd", fwd_a, 32'h5555_AAAA);
        chk("rst_stall", stall_a, 1'b0);
        chk("rst_wbv", wbv_a, 1'b0);
        chk("rst_cnt", cnt_a, 16'h0);
        rst_n = 1'b1;
        #1;
        chk("ex_bypass", fwd_a[15:0], 16'h1234);
        chk("ex_bypass_rf1", fwd_a[31:16], 16'h5555);
        chk("ex_bypass_stall", stall_a, 1'b0);
        tick;
        ex_dest = 4'd5; ex_result = 16'h0001;
        tick;
        ex_result = 16'h0002; rd_idx = 8'h53;
        #1;
        chk("young_ex", fwd_a[31:16], 16'h0002);
        chk("s2_fwd", fwd_a[15:0], 16'h1234);
        tick;
        ex_valid = 1'b0;
        #1;
        chk("young_s1", fwd_a[31:16], 16'h0002);
        chk("wb_s2_valid", wbv_a, 1'b1);
        chk("wb_s2_dest", wbd_a, 4'd5);
        chk("wb_s2_data", wbdat_a, 16'h0001);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 4'd7; ex_result = 16'h9999; rd_idx = 8'h17;
        #1;
        chk("lu_stall", stall_a, 1'b1);
        chk("lu_cnt0", cnt_a, 16'h0);
        tick;
        ex_valid = 1'b0; ex_is_load = 1'b0; mem_data = 16'hBEEF;
        #1;
        chk("lu_cnt1", cnt_a, 16'h1);
        chk("lu_nostall", stall_a, 1'b0);
        chk("lu_fwd", fwd_a[15:0], 16'hBEEF);
        tick;
        hold = 1'b1; mem_data = 16'h1111; ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 4'd8; rd_idx = 8'h18;
        #1;
        chk("lu_wbv", wbv_a, 1'b1);
        chk("lu_wbd", wbd_a, 4'd7);
        chk("lu_wbdat", wbdat_a, 16'hBEEF);
        chk("hold_stall", stall_a, 1'b1);
        repeat (3) tick;
        chk("hold_wbv", wbv_a, 1'b1);
        chk("hold_wbdat", wbdat_a, 16'hBEEF);
        chk("hold_cnt", cnt_a, 16'h1);
        hold = 1'b0; flush = 1'b1; ex_is_load = 1'b0; ex_dest = 4'd4; ex_result = 16'h4444; rd_idx = 8'h14;
        tick;
        flush = 1'b0; ex_valid = 1'b0;
        tick;
        chk("flush_wbv", wbv_a, 1'b0);
        chk("flush_cnt", cnt_a, 16'h1);
        ex_valid = 1'b1; ex_dest = 4'd0; ex_result = 16'h7777; rd_idx = 8'h10; rf_data = 32'h5555_AAAA;
        #1;
        chk("zr_fwd_b", fwd_b[15:0], 16'hAAAA);
        chk("zr_fwd_a", fwd_a[15:0], 16'h7777);
        tick;
        ex_valid = 1'b0;
        tick;
        chk("zr_wbv_a", wbv_a, 1'b1);
        chk("zr_wbd_a", wbd_a, 4'd0);
        chk("zr_wbdat_a", wbdat_a, 16'h7777);
        tick;
        chk("zr_wbv_b", wbv_b, 1'b0);
        repeat (2000) begin
            hold       = $urandom_range(0, 99) < 15;
            flush      = $urandom_range(0, 99) < 10;
            ex_valid   = $urandom_range(0, 99) < 70;
            ex_is_load = $urandom_range(0, 99) < 30;
            ex_dest    = 4'($urandom_range(0, 5));
            ex_result  = 16'($urandom);
            mem_data   = 16'($urandom);
            rd_idx     = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
            rf_data    = $urandom;
            tick;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wbv", wbv_a, 1'b0);
        chk("arst_cnt", cnt_a, 16'h0);
        chk("arst_fwd_a", fwd_a, rf_data);
        chk("arst_fwd_b", fwd_b, rf_data);
        chk("arst_stall", stall_a, 1'b0);
        hold = 1'b0; flush = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_dest = 4'd7; rd_idx = 8'h07;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (70000) tick;
        chk("sat_cnt_a", cnt_a, 16'hFFFF);
        chk("sat_cnt_b", cnt_b, 16'hFFFF);
        chk("sat_stall", stall_a, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
